// File: rtl/mips32_pkg.sv
// Shared opcode, funct, ALU-control and operand-select encodings for the Mips32 decode/execute slice.
package mips32_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LUI  = 4'd12
    } alu_ctrl_e;

    localparam logic [1:0] SRC_RS_RT    = 2'b00;
    localparam logic [1:0] SRC_RS_IMM   = 2'b01;
    localparam logic [1:0] SRC_RT_SHAMT = 2'b10;
    localparam logic [1:0] SRC_RT_RS    = 2'b11;

    function automatic alu_ctrl_e funct_to_ctrl(input logic [5:0] funct);
        alu_ctrl_e c;
        c = ALU_ADD;
        case (funct)
            FN_ADD, FN_ADDU: c = ALU_ADD;
            FN_SUB, FN_SUBU: c = ALU_SUB;
            FN_AND:          c = ALU_AND;
            FN_OR:           c = ALU_OR;
            FN_XOR:          c = ALU_XOR;
            FN_NOR:          c = ALU_NOR;
            FN_SLT:          c = ALU_SLT;
            FN_SLTU:         c = ALU_SLTU;
            FN_SLL, FN_SLLV: c = ALU_SLL;
            FN_SRL, FN_SRLV: c = ALU_SRL;
`ifdef ALU_SRA_EN
            FN_SRA, FN_SRAV: c = ALU_SRA;
`else
            FN_SRA, FN_SRAV: c = ALU_SRL;
`endif
            default:         c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational 32-bit ALU; arithmetic shift is only built when ALU_SRA_EN is defined.
module mips32_alu
    import mips32_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_ADD:  result = op1 + op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_NOR:  result = ~(op1 | op2);
            ALU_SLL:  result = op1 << shamt;
            ALU_SRL:  result = op1 >> shamt;
`ifdef ALU_SRA_EN
            ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
`else
            ALU_SRA:  result = '0;
`endif
            ALU_SUB:  result = op1 - op2;
            ALU_SLT:  result = {31'b0, $signed(op1) < $signed(op2)};
            ALU_SLTU: result = {31'b0, op1 < op2};
            // Inverted compare so a BNE is taken on zero, like BEQ
            ALU_NE:   result = {31'b0, op1 == op2};
            ALU_LUI:  result = {op2[15:0], 16'h0000};
            default:  result = '0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/mips32_decode_exec.sv
// Mips32 decode/execute slice: control + ALU-control decode, operand mux, ALU, one output register.
// Optional macro ALU_SRA_EN enables arithmetic right shift for funct 03/07.
module mips32_decode_exec
    import mips32_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter logic [5:0]  HALT_FUNCT = 6'h0D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             reg_dst,
    output logic             jump,
    output logic             branch,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_op,
    output logic [1:0]       alu_src,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             halt
);

    logic [5:0]  opcode, funct;
    logic [31:0] imm, shamt;
    logic        unused_reg_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm    = {{16{instr[15]}}, instr[15:0]};
    assign shamt  = {27'b0, instr[10:6]};
    // Register numbers are consumed by the register file, not here
    assign unused_reg_fields = ^instr[25:16];

    logic       reg_dst_d, jump_d, branch_d, mem_to_reg_d, mem_write_d, reg_write_d, alu_op_d;
    logic       halt_d;
    logic [1:0] alu_src_d;
    alu_ctrl_e  alu_ctrl_d;

    always_comb begin
        reg_dst_d    = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        alu_op_d     = 1'b0;
        halt_d       = 1'b0;
        alu_src_d    = SRC_RS_RT;
        alu_ctrl_d   = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_d   = 1'b1;
                alu_op_d    = 1'b1;
                halt_d      = (funct == HALT_FUNCT);
                reg_write_d = !halt_d;
                alu_ctrl_d  = funct_to_ctrl(funct);
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA:    alu_src_d = SRC_RT_SHAMT;
                    FN_SLLV, FN_SRLV, FN_SRAV: alu_src_d = SRC_RT_RS;
                    default:                   alu_src_d = SRC_RS_RT;
                endcase
            end
            OP_ADDI: begin reg_write_d = 1'b1; alu_src_d = SRC_RS_IMM; alu_ctrl_d = ALU_ADD; end
            OP_ANDI: begin reg_write_d = 1'b1; alu_src_d = SRC_RS_IMM; alu_ctrl_d = ALU_AND; end
            OP_ORI:  begin reg_write_d = 1'b1; alu_src_d = SRC_RS_IMM; alu_ctrl_d = ALU_OR;  end
            OP_SLTI: begin reg_write_d = 1'b1; alu_src_d = SRC_RS_IMM; alu_ctrl_d = ALU_SLT; end
            OP_LUI:  begin reg_write_d = 1'b1; alu_src_d = SRC_RS_IMM; alu_ctrl_d = ALU_LUI; end
            OP_LW: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                alu_src_d    = SRC_RS_IMM;
            end
            OP_SW:   begin mem_write_d = 1'b1; alu_src_d = SRC_RS_IMM; end
            OP_BEQ:  begin branch_d = 1'b1; alu_ctrl_d = ALU_SUB; end
            OP_BNE:  begin branch_d = 1'b1; alu_ctrl_d = ALU_NE;  end
            OP_J:    jump_d = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] op1, op2, alu_result;
    logic        alu_zero;

    always_comb begin
        op1 = rs_data;
        op2 = rt_data;
        case (alu_src_d)
            SRC_RS_RT:    begin op1 = rs_data; op2 = rt_data; end
            SRC_RS_IMM:   begin op1 = rs_data; op2 = imm;     end
            SRC_RT_SHAMT: begin op1 = rt_data; op2 = shamt;   end
            SRC_RT_RS:    begin op1 = rt_data; op2 = rs_data; end
            default:      ;
        endcase
    end

    mips32_alu u_alu (
        .ctrl   (alu_ctrl_d),
        .op1    (op1),
        .op2    (op2),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_dst    <= 1'b0;
            jump       <= 1'b0;
            branch     <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= 1'b0;
            alu_src    <= 2'b00;
            alu_ctrl   <= 4'd0;
            result     <= '0;
            zero       <= 1'b0;
            halt       <= 1'b0;
        end else begin
            reg_dst    <= reg_dst_d;
            jump       <= jump_d;
            branch     <= branch_d;
            mem_to_reg <= mem_to_reg_d;
            mem_write  <= mem_write_d;
            reg_write  <= reg_write_d;
            alu_op     <= alu_op_d;
            alu_src    <= alu_src_d;
            alu_ctrl   <= alu_ctrl_d;
            result     <= alu_result;
            zero       <= alu_zero;
            halt       <= halt_d;
        end
    end

endmodule

// File: tb/tb_mips32_decode_exec.sv
// Directed table-driven bench for mips32_decode_exec, plus reset sequences.
module tb_mips32_decode_exec;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic        reg_dst, jump, branch, mem_to_reg, mem_write, reg_write, alu_op, zero, halt;
    logic [1:0]  alu_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    mips32_decode_exec dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .reg_dst    (reg_dst),
        .jump       (jump),
        .branch     (branch),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .result     (result),
        .zero       (zero),
        .halt       (halt)
    );

    always #5 clock = ~clock;

    // ctl = {reg_dst, jump, branch, mem_to_reg, mem_write, reg_write, alu_op, halt}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [7:0]  ctl;
        logic [1:0]  src;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {reg_dst, jump, branch, mem_to_reg, mem_write, reg_write, alu_op, halt};
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, ".ctl"}, {24'b0, ctl_now()}, 32'h0);
        chk({name, ".src_ctrl"}, {26'b0, alu_src, alu_ctrl}, 32'h0);
        chk({name, ".result"}, result, 32'h0);
        chk({name, ".zero"}, {31'b0, zero}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{"add",   32'h012A4020, 32'd5,        32'd7,        8'h86, 2'd0, 4'd2,  32'd12,       1'b0};
        vecs[1]  = '{"beq",   32'h114B0001, 32'd3,        32'd3,        8'h20, 2'd0, 4'd8,  32'd0,        1'b1};
        vecs[2]  = '{"bne",   32'h154B0001, 32'd3,        32'd4,        8'h20, 2'd0, 4'd11, 32'd0,        1'b1};
        vecs[3]  = '{"addi",  32'h2128FFFF, 32'd1,        32'd0,        8'h04, 2'd1, 4'd2,  32'd0,        1'b1};
        vecs[4]  = '{"lui",   32'h3C081234, 32'd0,        32'd0,        8'h04, 2'd1, 4'd12, 32'h12340000, 1'b0};
        vecs[5]  = '{"lw",    32'h8D280004, 32'h100,      32'd0,        8'h14, 2'd1, 4'd2,  32'h104,      1'b0};
        vecs[6]  = '{"sw",    32'hAD280008, 32'h100,      32'd0,        8'h08, 2'd1, 4'd2,  32'h108,      1'b0};
        vecs[7]  = '{"sll",   32'h00094100, 32'd0,        32'h0000000F, 8'h86, 2'd2, 4'd5,  32'h000000F0, 1'b0};
`ifdef ALU_SRA_EN
        vecs[8]  = '{"srav",  32'h01494007, 32'd4,        32'h80000000, 8'h86, 2'd3, 4'd7,  32'hF8000000, 1'b0};
        vecs[19] = '{"sra",   32'h00094083, 32'd0,        32'h80000000, 8'h86, 2'd2, 4'd7,  32'hE0000000, 1'b0};
`else
        vecs[8]  = '{"srav",  32'h01494007, 32'd4,        32'h80000000, 8'h86, 2'd3, 4'd6,  32'h08000000, 1'b0};
        vecs[19] = '{"sra",   32'h00094083, 32'd0,        32'h80000000, 8'h86, 2'd2, 4'd6,  32'h20000000, 1'b0};
`endif
        vecs[9]  = '{"halt",  32'h0000000D, 32'd0,        32'd0,        8'h83, 2'd0, 4'd2,  32'd0,        1'b1};
        vecs[10] = '{"j",     32'h08000010, 32'd1,        32'd2,        8'h40, 2'd0, 4'd2,  32'd3,        1'b0};
        vecs[11] = '{"slt",   32'h0149402A, 32'hFFFFFFFF, 32'd1,        8'h86, 2'd0, 4'd9,  32'd1,        1'b0};
        vecs[12] = '{"sltu",  32'h0149402B, 32'hFFFFFFFF, 32'd1,        8'h86, 2'd0, 4'd10, 32'd0,        1'b1};
        vecs[13] = '{"sub",   32'h01494022, 32'd5,        32'd7,        8'h86, 2'd0, 4'd8,  32'hFFFFFFFE, 1'b0};
        vecs[14] = '{"nor",   32'h01494027, 32'd0,        32'd0,        8'h86, 2'd0, 4'd4,  32'hFFFFFFFF, 1'b0};
        vecs[15] = '{"andi",  32'h312800F0, 32'hFF,       32'd0,        8'h04, 2'd1, 4'd0,  32'hF0,       1'b0};
        vecs[16] = '{"ori",   32'h35280F00, 32'hFF,       32'd0,        8'h04, 2'd1, 4'd1,  32'hFFF,      1'b0};
        vecs[17] = '{"slti",  32'h2928FFFF, 32'hFFFFFFFE, 32'd0,        8'h04, 2'd1, 4'd9,  32'd1,        1'b0};
        vecs[18] = '{"undef", 32'hFC000000, 32'd2,        32'd2,        8'h00, 2'd0, 4'd2,  32'd4,        1'b0};
        vecs[20] = '{"xor",   32'h01494026, 32'hF0F0,     32'hFF00,     8'h86, 2'd0, 4'd3,  32'h0FF0,     1'b0};
        vecs[21] = '{"srl",   32'h00094102, 32'd0,        32'hF0,       8'h86, 2'd2, 4'd6,  32'h0000000F, 1'b0};

        // Reset held across edges with live add inputs: outputs must stay zero
        instr = 32'h012A4020; rs_data = 32'd5; rt_data = 32'd7;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset_held");

        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_all_zero("after_release_no_edge");
        @(posedge clock);
        #1;
        chk("first_edge.result", result, 32'd12);
        chk("first_edge.ctl", {24'b0, ctl_now()}, 32'h86);
        chk("first_edge.ctrl", {28'b0, alu_ctrl}, 32'd2);
        chk("first_edge.zero", {31'b0, zero}, 32'd0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            instr = vecs[i].instr; rs_data = vecs[i].rs; rt_data = vecs[i].rt;
            @(posedge clock);
            #1;
            chk({vecs[i].name, ".ctl"}, {24'b0, ctl_now()}, {24'b0, vecs[i].ctl});
            chk({vecs[i].name, ".src"}, {30'b0, alu_src}, {30'b0, vecs[i].src});
            chk({vecs[i].name, ".ctrl"}, {28'b0, alu_ctrl}, {28'b0, vecs[i].ctrl});
            chk({vecs[i].name, ".result"}, result, vecs[i].res);
            chk({vecs[i].name, ".zero"}, {31'b0, zero}, {31'b0, vecs[i].z});
        end

        // Outputs hold their value until the next edge even if inputs change
        @(negedge clock);
        instr = 32'h012A4020; rs_data = 32'd100; rt_data = 32'd23;
        #1;
        chk("hold.result", result, 32'h0000000F);
        @(posedge clock);
        #1;
        chk("hold_next.result", result, 32'd123);

        // Asynchronous reset mid-cycle clears outputs before any edge
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_async.result", result, 32'd123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

endmodule
